alu_core: RTL and testbench
===========================

ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 Parameter OP_WIDTH, default 8, operand width.
REQ-002 Parameter CMD_WIDTH, default 4, command width.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ce  in  1  clock enable; 0 freezes all state and outputs.
REQ-006 mode  in  1  1 = arithmetic, 0 = logic.
REQ-007 cmd  in  CMD_WIDTH  operation code.
REQ-008 inp_valid  in  2  bit0 = opa valid, bit1 = opb valid.
REQ-009 cin  in  1  carry in.
REQ-010 opa, opb  in  OP_WIDTH each  operands.
REQ-011 res  out  2*OP_WIDTH  result; zero-extended for non-multiply ops.
REQ-012 cout, oflow, g, l, e, err  out  1 each  carry, overflow, greater, less, equal, error flags.

Function
REQ-013 Arith codes: ADD=0 SUB=1 ADD_CIN=2 SUB_CIN=3 INC_A=4 DEC_A=5 INC_B=6 DEC_B=7 CMP=8 INC_MUL=9 SHL_MUL=10.
REQ-014 Logic codes: AND=0 NAND=1 OR=2 NOR=3 XOR=4 XNOR=5 NOT_A=6 NOT_B=7 SHR1_A=8 SHL1_A=9 SHR1_B=10 SHL1_B=11 ROL=12 ROR=13.
REQ-015 Unlisted mode/cmd pair: res=0, err=1, other flags 0.
REQ-016 Single-operand ops need only their operand's valid bit; wrong valid bit gives err=1, res=0.
REQ-017 Two-operand ops (ADD, SUB, ADD_CIN, SUB_CIN, CMP, INC_MUL, SHL_MUL, AND..XNOR, ROL, ROR) execute when inp_valid=11.
REQ-018 FSM states: IDLE, WAIT_OP, EXEC, MUL1, MUL2.
REQ-019 IDLE: inputs captured in input register when ce=1; two-operand op with inp_valid 01/10: latch present operand, mode, cmd, cin; go WAIT_OP.
REQ-020 WAIT_OP: 4-bit counter counts ce=1 cycles; inp_valid=11 -> load both operands, go EXEC; counter reaches 16 -> err=1, res=0, go IDLE.
REQ-021 WAIT_OP ignores cmd/mode changes; latched command is used.
REQ-022 Latency: non-multiply result and flags appear 2 ce-cycles after the cycle inp_valid completes (input reg + output reg).
REQ-023 INC_MUL res=(opa+1)*(opb+1); SHL_MUL res=(opa<<1)*opb, both modulo 2**(2*OP_WIDTH); latency 3 ce-cycles via MUL1, MUL2.
REQ-024 No new command accepted during MUL1/MUL2; inputs then are ignored.
REQ-025 ADD/ADD_CIN: cout = bit OP_WIDTH of sum; SUB/SUB_CIN: oflow=1 when opa<opb (borrow), or opa<opb+cin.
REQ-026 INC/DEC wrap at OP_WIDTH+1 bits; cout/oflow set on carry/borrow out of OP_WIDTH bits.
REQ-027 CMP: exactly one of g, l, e asserted; res=0.
REQ-028 ROL/ROR rotate opa by opb[log2(OP_WIDTH)-1:0]; any higher opb bit set -> err=1, result still produced.
REQ-029 Flags not relevant to an op are driven 0.
REQ-030 ce=0: outputs, FSM, counter hold; ce=0 during WAIT_OP does not advance timeout.

Reset
REQ-031 rst=1 at a clock edge: next cycle res=0, cout=oflow=g=l=e=err=0, FSM=IDLE, counter=0.
REQ-032 rst overrides ce and aborts WAIT_OP or MUL mid-operation with no result.
REQ-033 Outputs are never X after the first reset edge.

Structure
REQ-034 Package alu_pkg holds OP_WIDTH/CMD_WIDTH defaults, command code constants, FSM state enum, timeout constant 16.
REQ-035 Sub-module alu_mul_pipe implements the two-stage registered multiplier with ce.
REQ-036 Outputs registered only; no combinational input-to-output path.

Verification
REQ-037 mode=1 cmd=ADD opa=8'hFF opb=8'h01 inp_valid=11 -> 2 cycles later res=16'h0100, cout=1.
REQ-038 mode=1 cmd=CMP opa=5 opb=9 -> 2 cycles later l=1, g=0, e=0.
REQ-039 mode=0 cmd=AND inp_valid=01 opa=8'hF0, then 16 ce-cycles of 01 -> err=1, res=0, FSM IDLE.
REQ-040 mode=1 cmd=INC_MUL opa=3 opb=4, inp_valid=10 then 11 after 5 cycles -> 3 cycles later res=20.
REQ-041 cmd=SUB in flight, ce=0 for 4 cycles -> outputs frozen, result appears after ce resumes.
REQ-042 rst asserted during MUL1 -> next cycle all outputs 0, no multiply result emitted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants, command codes, FSM state type and operand-need decode for the ALU core.
package alu_pkg;

    localparam int unsigned OP_WIDTH_DEF   = 8;
    localparam int unsigned CMD_WIDTH_DEF  = 4;
    localparam int unsigned TIMEOUT_CYCLES = 16;

    // Arithmetic commands (mode = 1)
    localparam int unsigned CMD_ADD     = 0;
    localparam int unsigned CMD_SUB     = 1;
    localparam int unsigned CMD_ADD_CIN = 2;
    localparam int unsigned CMD_SUB_CIN = 3;
    localparam int unsigned CMD_INC_A   = 4;
    localparam int unsigned CMD_DEC_A   = 5;
    localparam int unsigned CMD_INC_B   = 6;
    localparam int unsigned CMD_DEC_B   = 7;
    localparam int unsigned CMD_CMP     = 8;
    localparam int unsigned CMD_INC_MUL = 9;
    localparam int unsigned CMD_SHL_MUL = 10;

    // Logic commands (mode = 0)
    localparam int unsigned CMD_AND    = 0;
    localparam int unsigned CMD_NAND   = 1;
    localparam int unsigned CMD_OR     = 2;
    localparam int unsigned CMD_NOR    = 3;
    localparam int unsigned CMD_XOR    = 4;
    localparam int unsigned CMD_XNOR   = 5;
    localparam int unsigned CMD_NOT_A  = 6;
    localparam int unsigned CMD_NOT_B  = 7;
    localparam int unsigned CMD_SHR1_A = 8;
    localparam int unsigned CMD_SHL1_A = 9;
    localparam int unsigned CMD_SHR1_B = 10;
    localparam int unsigned CMD_SHL1_B = 11;
    localparam int unsigned CMD_ROL    = 12;
    localparam int unsigned CMD_ROR    = 13;

    typedef enum logic [2:0] {
        StIdle,
        StWaitOp,
        StExec,
        StMul1,
        StMul2
    } alu_state_e;

    typedef struct packed {
        logic cout;
        logic oflow;
        logic g;
        logic l;
        logic e;
        logic err;
    } alu_flags_t;

    // Operand valid bits a command needs; 2'b00 marks an unlisted mode/cmd pair.
    function automatic logic [1:0] valid_need(input logic mode, input int unsigned c);
        logic [1:0] need;
        need = 2'b00;
        if (mode) begin
            case (c)
                CMD_ADD, CMD_SUB, CMD_ADD_CIN, CMD_SUB_CIN,
                CMD_CMP, CMD_INC_MUL, CMD_SHL_MUL:          need = 2'b11;
                CMD_INC_A, CMD_DEC_A:                       need = 2'b01;
                CMD_INC_B, CMD_DEC_B:                       need = 2'b10;
                default:                                    need = 2'b00;
            endcase
        end else begin
            case (c)
                CMD_AND, CMD_NAND, CMD_OR, CMD_NOR,
                CMD_XOR, CMD_XNOR, CMD_ROL, CMD_ROR:        need = 2'b11;
                CMD_NOT_A, CMD_SHR1_A, CMD_SHL1_A:          need = 2'b01;
                CMD_NOT_B, CMD_SHR1_B, CMD_SHL1_B:          need = 2'b10;
                default:                                    need = 2'b00;
            endcase
        end
        return need;
    endfunction

    function automatic logic is_mul(input logic mode, input int unsigned c);
        return mode && ((c == CMD_INC_MUL) || (c == CMD_SHL_MUL));
    endfunction

endpackage

// File: rtl/alu_mul_pipe.sv
// Two-stage registered multiplier: stage 1 prepares the operands, stage 2 registers the product.
module alu_mul_pipe
    import alu_pkg::*;
#(
    parameter int unsigned OP_WIDTH = OP_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ce_i,
    input  logic                  load_i,
    input  logic                  shl_i,
    input  logic [OP_WIDTH-1:0]   a_i,
    input  logic [OP_WIDTH-1:0]   b_i,
    output logic [2*OP_WIDTH-1:0] prod_o
);

    localparam int unsigned W2 = 2 * OP_WIDTH;

    logic [W2-1:0] ma_q, ma_d;
    logic [W2-1:0] mb_q, mb_d;
    logic [W2-1:0] prod_q, prod_d;

    always_comb begin
        ma_d = ma_q;
        mb_d = mb_q;
        if (load_i) begin
            if (shl_i) begin
                ma_d = W2'(a_i) << 1;
                mb_d = W2'(b_i);
            end else begin
                ma_d = W2'(a_i) + W2'(1);
                mb_d = W2'(b_i) + W2'(1);
            end
        end
        // Truncation to W2 bits gives the modulo-2**(2*OP_WIDTH) product.
        prod_d = ma_q * mb_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ma_q   <= '0;
            mb_q   <= '0;
            prod_q <= '0;
        end else if (ce_i) begin
            ma_q   <= ma_d;
            mb_q   <= mb_d;
            prod_q <= prod_d;
        end
    end

    assign prod_o = prod_q;

endmodule

// File: rtl/alu_core.sv
// Registered ALU with operand-wait FSM, timeout, and a pipelined multiply path.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned OP_WIDTH  = OP_WIDTH_DEF,
    parameter int unsigned CMD_WIDTH = CMD_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  mode,
    input  logic [CMD_WIDTH-1:0]  cmd,
    input  logic [1:0]            inp_valid,
    input  logic                  cin,
    input  logic [OP_WIDTH-1:0]   opa,
    input  logic [OP_WIDTH-1:0]   opb,
    output logic [2*OP_WIDTH-1:0] res,
    output logic                  cout,
    output logic                  oflow,
    output logic                  g,
    output logic                  l,
    output logic                  e,
    output logic                  err
);

    localparam int unsigned W     = OP_WIDTH;
    localparam int unsigned W2    = 2 * OP_WIDTH;
    localparam int unsigned SHW   = $clog2(OP_WIDTH);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W:0]  ONE_X = (W + 1)'(1);

    alu_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  in_mode_q, in_mode_d;
    logic [CMD_WIDTH-1:0]  in_cmd_q, in_cmd_d;
    logic                  in_cin_q, in_cin_d;
    logic [1:0]            in_valid_q, in_valid_d;
    logic [W-1:0]          in_a_q, in_a_d;
    logic [W-1:0]          in_b_q, in_b_d;
    logic [W2-1:0]         res_q, res_d;
    alu_flags_t            flags_q, flags_d;

    int unsigned           cmd_in_u, cmd_q_u;
    logic [1:0]            need_in, need_q;
    logic                  mul_load, mul_shl;
    logic [W2-1:0]         mul_prod;

    logic [W:0]            a_x, b_x, arith;
    logic [W-1:0]          logic_r, rot_l, rot_r;
    logic [SHW-1:0]        sh, idx_l, idx_r;
    logic [W2-1:0]         exec_res;
    alu_flags_t            exec_flags;

    assign cmd_in_u = 32'(cmd);
    assign cmd_q_u  = 32'(in_cmd_q);
    assign need_in  = valid_need(mode, cmd_in_u);
    assign need_q   = valid_need(in_mode_q, cmd_q_u);

    alu_mul_pipe #(
        .OP_WIDTH (OP_WIDTH)
    ) u_mul_pipe (
        .clk_i  (clk),
        .rst_i  (rst),
        .ce_i   (ce),
        .load_i (mul_load),
        .shl_i  (mul_shl),
        .a_i    (opa),
        .b_i    (opb),
        .prod_o (mul_prod)
    );

    // Execute unit: combinational over the input register, consumed only in StExec.
    always_comb begin
        exec_res   = '0;
        exec_flags = '0;
        arith      = '0;
        logic_r    = '0;
        a_x        = {1'b0, in_a_q};
        b_x        = {1'b0, in_b_q};
        sh         = in_b_q[SHW-1:0];
        rot_l      = '0;
        rot_r      = '0;
        idx_l      = '0;
        idx_r      = '0;
        // Index arithmetic wraps at SHW bits, so OP_WIDTH is assumed a power of two.
        for (int j = 0; j < W; j++) begin
            idx_l    = SHW'(j) - sh;
            idx_r    = SHW'(j) + sh;
            rot_l[j] = in_a_q[idx_l];
            rot_r[j] = in_a_q[idx_r];
        end

        if ((need_q == 2'b00) || ((need_q & in_valid_q) != need_q)) begin
            exec_flags.err = 1'b1;
        end else if (in_mode_q) begin
            case (cmd_q_u)
                CMD_ADD: begin
                    arith           = a_x + b_x;
                    exec_flags.cout = arith[W];
                end
                CMD_ADD_CIN: begin
                    arith           = a_x + b_x + (W + 1)'(in_cin_q);
                    exec_flags.cout = arith[W];
                end
                CMD_SUB: begin
                    arith            = a_x - b_x;
                    exec_flags.oflow = (in_a_q < in_b_q);
                end
                CMD_SUB_CIN: begin
                    arith            = a_x - b_x - (W + 1)'(in_cin_q);
                    exec_flags.oflow = (a_x < (b_x + (W + 1)'(in_cin_q)));
                end
                CMD_INC_A: begin
                    arith           = a_x + ONE_X;
                    exec_flags.cout = arith[W];
                end
                CMD_DEC_A: begin
                    arith            = a_x - ONE_X;
                    exec_flags.oflow = (in_a_q == '0);
                end
                CMD_INC_B: begin
                    arith           = b_x + ONE_X;
                    exec_flags.cout = arith[W];
                end
                CMD_DEC_B: begin
                    arith            = b_x - ONE_X;
                    exec_flags.oflow = (in_b_q == '0);
                end
                CMD_CMP: begin
                    exec_flags.g = (in_a_q > in_b_q);
                    exec_flags.l = (in_a_q < in_b_q);
                    exec_flags.e = (in_a_q == in_b_q);
                end
                default: ;
            endcase
            exec_res = W2'(arith);
        end else begin
            case (cmd_q_u)
                CMD_AND:    logic_r = in_a_q & in_b_q;
                CMD_NAND:   logic_r = ~(in_a_q & in_b_q);
                CMD_OR:     logic_r = in_a_q | in_b_q;
                CMD_NOR:    logic_r = ~(in_a_q | in_b_q);
                CMD_XOR:    logic_r = in_a_q ^ in_b_q;
                CMD_XNOR:   logic_r = ~(in_a_q ^ in_b_q);
                CMD_NOT_A:  logic_r = ~in_a_q;
                CMD_NOT_B:  logic_r = ~in_b_q;
                CMD_SHR1_A: logic_r = in_a_q >> 1;
                CMD_SHL1_A: logic_r = in_a_q << 1;
                CMD_SHR1_B: logic_r = in_b_q >> 1;
                CMD_SHL1_B: logic_r = in_b_q << 1;
                CMD_ROL: begin
                    logic_r        = rot_l;
                    exec_flags.err = |in_b_q[W-1:SHW];
                end
                CMD_ROR: begin
                    logic_r        = rot_r;
                    exec_flags.err = |in_b_q[W-1:SHW];
                end
                default: ;
            endcase
            exec_res = W2'(logic_r);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        in_mode_d  = in_mode_q;
        in_cmd_d   = in_cmd_q;
        in_cin_d   = in_cin_q;
        in_valid_d = in_valid_q;
        in_a_d     = in_a_q;
        in_b_d     = in_b_q;
        res_d      = res_q;
        flags_d    = flags_q;
        mul_load   = 1'b0;
        mul_shl    = 1'b0;

        case (state_q)
            StIdle: begin
                in_mode_d  = mode;
                in_cmd_d   = cmd;
                in_cin_d   = cin;
                in_valid_d = inp_valid;
                in_a_d     = opa;
                in_b_d     = opb;
                cnt_d      = '0;
                if (inp_valid != 2'b00) begin
                    if ((need_in == 2'b11) && (inp_valid != 2'b11)) begin
                        state_d = StWaitOp;
                    end else if ((need_in == 2'b11) && is_mul(mode, cmd_in_u)) begin
                        state_d  = StMul1;
                        mul_load = 1'b1;
                        mul_shl  = (cmd_in_u == CMD_SHL_MUL);
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StWaitOp: begin
                // Latched mode/cmd/cin stay in force; only the operands are reloaded.
                if (inp_valid == 2'b11) begin
                    in_a_d     = opa;
                    in_b_d     = opb;
                    in_valid_d = 2'b11;
                    cnt_d      = '0;
                    if (is_mul(in_mode_q, cmd_q_u)) begin
                        state_d  = StMul1;
                        mul_load = 1'b1;
                        mul_shl  = (cmd_q_u == CMD_SHL_MUL);
                    end else begin
                        state_d = StExec;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    res_d       = '0;
                    flags_d     = '0;
                    flags_d.err = 1'b1;
                    cnt_d       = '0;
                    state_d     = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StExec: begin
                res_d   = exec_res;
                flags_d = exec_flags;
                state_d = StIdle;
            end
            StMul1: begin
                state_d = StMul2;
            end
            StMul2: begin
                res_d   = mul_prod;
                flags_d = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            in_mode_q  <= 1'b0;
            in_cmd_q   <= '0;
            in_cin_q   <= 1'b0;
            in_valid_q <= 2'b00;
            in_a_q     <= '0;
            in_b_q     <= '0;
            res_q      <= '0;
            flags_q    <= '0;
        end else if (ce) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_mode_q  <= in_mode_d;
            in_cmd_q   <= in_cmd_d;
            in_cin_q   <= in_cin_d;
            in_valid_q <= in_valid_d;
            in_a_q     <= in_a_d;
            in_b_q     <= in_b_d;
            res_q      <= res_d;
            flags_q    <= flags_d;
        end
    end

    assign res   = res_q;
    assign cout  = flags_q.cout;
    assign oflow = flags_q.oflow;
    assign g     = flags_q.g;
    assign l     = flags_q.l;
    assign e     = flags_q.e;
    assign err   = flags_q.err;

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core with hand-computed results and flags.
module tb_alu_core;

    // Flag vector order: {cout, oflow, g, l, e, err}
    localparam logic [5:0] F_NONE  = 6'b000000;
    localparam logic [5:0] F_COUT  = 6'b100000;
    localparam logic [5:0] F_OFLOW = 6'b010000;
    localparam logic [5:0] F_G     = 6'b001000;
    localparam logic [5:0] F_L     = 6'b000100;
    localparam logic [5:0] F_E     = 6'b000010;
    localparam logic [5:0] F_ERR   = 6'b000001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b1;
    logic        mode = 1'b0;
    logic [3:0]  cmd = 4'd0;
    logic [1:0]  inp_valid = 2'b00;
    logic        cin = 1'b0;
    logic [7:0]  opa = 8'h00;
    logic [7:0]  opb = 8'h00;
    logic [15:0] res;
    logic        cout, oflow, g, l, e, err;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    alu_core #(
        .OP_WIDTH  (8),
        .CMD_WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .mode      (mode),
        .cmd       (cmd),
        .inp_valid (inp_valid),
        .cin       (cin),
        .opa       (opa),
        .opb       (opb),
        .res       (res),
        .cout      (cout),
        .oflow     (oflow),
        .g         (g),
        .l         (l),
        .e         (e),
        .err       (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [15:0] exp_res,
                             input logic [5:0] exp_flags);
        check_eq({tag, ".res"}, 32'(res), 32'(exp_res));
        check_eq({tag, ".flags"}, 32'({cout, oflow, g, l, e, err}), 32'(exp_flags));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m, input logic [3:0] c, input logic [1:0] v,
                         input logic [7:0] a, input logic [7:0] b, input logic ci);
        mode      = m;
        cmd       = c;
        inp_valid = v;
        opa       = a;
        opb       = b;
        cin       = ci;
    endtask

    task automatic go_idle();
        inp_valid = 2'b00;
    endtask

    // One non-multiply op: capture edge, then output edge.
    task automatic run_op(input string tag, input logic m, input logic [3:0] c,
                          input logic [1:0] v, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic [15:0] exp_res,
                          input logic [5:0] exp_flags);
        drive(m, c, v, a, b, ci);
        tick();
        go_idle();
        tick();
        check_out(tag, exp_res, exp_flags);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check_out("reset", 16'h0000, F_NONE);

        // Arithmetic
        run_op("add_ff_01",    1, 4'd0, 2'b11, 8'hFF, 8'h01, 0, 16'h0100, F_COUT);
        run_op("add_12_34",    1, 4'd0, 2'b11, 8'h12, 8'h34, 0, 16'h0046, F_NONE);
        run_op("add_cin",      1, 4'd2, 2'b11, 8'h7F, 8'h80, 1, 16'h0100, F_COUT);
        run_op("sub_borrow",   1, 4'd1, 2'b11, 8'h05, 8'h09, 0, 16'h01FC, F_OFLOW);
        run_op("sub_plain",    1, 4'd1, 2'b11, 8'h09, 8'h05, 0, 16'h0004, F_NONE);
        run_op("sub_cin",      1, 4'd3, 2'b11, 8'h05, 8'h05, 1, 16'h01FF, F_OFLOW);
        run_op("inc_a_wrap",   1, 4'd4, 2'b01, 8'hFF, 8'h00, 0, 16'h0100, F_COUT);
        run_op("dec_a_zero",   1, 4'd5, 2'b01, 8'h00, 8'h00, 0, 16'h01FF, F_OFLOW);
        run_op("inc_b",        1, 4'd6, 2'b10, 8'h00, 8'h07, 0, 16'h0008, F_NONE);
        run_op("dec_b",        1, 4'd7, 2'b10, 8'h00, 8'h10, 0, 16'h000F, F_NONE);
        run_op("inc_a_badv",   1, 4'd4, 2'b10, 8'h11, 8'h22, 0, 16'h0000, F_ERR);
        run_op("cmp_lt",       1, 4'd8, 2'b11, 8'h05, 8'h09, 0, 16'h0000, F_L);
        run_op("cmp_gt",       1, 4'd8, 2'b11, 8'h09, 8'h05, 0, 16'h0000, F_G);
        run_op("cmp_eq",       1, 4'd8, 2'b11, 8'h07, 8'h07, 0, 16'h0000, F_E);
        run_op("arith_bad",    1, 4'd11, 2'b11, 8'h01, 8'h01, 0, 16'h0000, F_ERR);

        // Logic
        run_op("and",          0, 4'd0, 2'b11, 8'hF0, 8'h3C, 0, 16'h0030, F_NONE);
        run_op("nand",         0, 4'd1, 2'b11, 8'hF0, 8'h3C, 0, 16'h00CF, F_NONE);
        run_op("or",           0, 4'd2, 2'b11, 8'hF0, 8'h0F, 0, 16'h00FF, F_NONE);
        run_op("nor",          0, 4'd3, 2'b11, 8'hF0, 8'h0C, 0, 16'h0003, F_NONE);
        run_op("xor",          0, 4'd4, 2'b11, 8'hAA, 8'hFF, 0, 16'h0055, F_NONE);
        run_op("xnor",         0, 4'd5, 2'b11, 8'hAA, 8'h0F, 0, 16'h005A, F_NONE);
        run_op("not_a",        0, 4'd6, 2'b01, 8'h5A, 8'h00, 0, 16'h00A5, F_NONE);
        run_op("not_b",        0, 4'd7, 2'b10, 8'h00, 8'h0F, 0, 16'h00F0, F_NONE);
        run_op("shr1_a",       0, 4'd8, 2'b01, 8'h81, 8'h00, 0, 16'h0040, F_NONE);
        run_op("shl1_a",       0, 4'd9, 2'b01, 8'h81, 8'h00, 0, 16'h0002, F_NONE);
        run_op("shr1_b",       0, 4'd10, 2'b10, 8'h00, 8'h02, 0, 16'h0001, F_NONE);
        run_op("shl1_b",       0, 4'd11, 2'b10, 8'h00, 8'hC0, 0, 16'h0080, F_NONE);
        run_op("not_b_badv",   0, 4'd7, 2'b01, 8'h00, 8'h0F, 0, 16'h0000, F_ERR);
        run_op("rol_1",        0, 4'd12, 2'b11, 8'h81, 8'h01, 0, 16'h0003, F_NONE);
        run_op("ror_1",        0, 4'd13, 2'b11, 8'h81, 8'h01, 0, 16'h00C0, F_NONE);
        run_op("rol_4",        0, 4'd12, 2'b11, 8'h12, 8'h04, 0, 16'h0021, F_NONE);
        run_op("ror_hi_bit",   0, 4'd13, 2'b11, 8'h81, 8'h09, 0, 16'h00C0, F_ERR);
        run_op("logic_bad",    0, 4'd14, 2'b11, 8'h01, 8'h01, 0, 16'h0000, F_ERR);

        // INC_MUL with opb first, both valid after 5 cycles
        run_op("pre_mul",      0, 4'd0, 2'b11, 8'hF0, 8'h3C, 0, 16'h0030, F_NONE);
        drive(1, 4'd9, 2'b10, 8'h03, 8'h04, 0);
        for (int i = 0; i < 5; i++) tick();
        drive(1, 4'd9, 2'b11, 8'h03, 8'h04, 0);
        tick();
        go_idle();
        tick();
        check_eq("inc_mul_early", 32'(res), 32'h0030);
        tick();
        check_out("inc_mul", 16'd20, F_NONE);

        // SHL_MUL; a valid ADD during MUL1/MUL2 must be ignored
        drive(1, 4'd10, 2'b11, 8'h81, 8'h03, 0);
        tick();
        drive(1, 4'd0, 2'b11, 8'h01, 8'h01, 0);
        tick();
        tick();
        go_idle();
        check_out("shl_mul", 16'h0306, F_NONE);
        tick();
        check_eq("shl_mul_hold", 32'(res), 32'h0306);

        drive(1, 4'd9, 2'b11, 8'hFF, 8'hFF, 0);
        tick();
        go_idle();
        tick();
        tick();
        check_out("inc_mul_wrap", 16'h0000, F_NONE);

        // Timeout: 15 wait cycles still pending, the 16th flags err
        run_op("pre_tmo",      1, 4'd0, 2'b11, 8'h10, 8'h20, 0, 16'h0030, F_NONE);
        drive(0, 4'd0, 2'b01, 8'hF0, 8'h00, 0);
        tick();
        for (int i = 0; i < 15; i++) tick();
        check_out("tmo_pending", 16'h0030, F_NONE);
        tick();
        check_out("tmo_fire", 16'h0000, F_ERR);
        run_op("after_tmo",    1, 4'd0, 2'b11, 8'h01, 8'h02, 0, 16'h0003, F_NONE);

        // ce=0 during WAIT_OP must not advance the timeout
        drive(0, 4'd4, 2'b01, 8'hAA, 8'h00, 0);
        tick();
        ce = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        ce = 1'b1;
        drive(1, 4'd0, 2'b11, 8'hAA, 8'hFF, 0);
        tick();
        go_idle();
        tick();
        check_out("wait_ce_hold", 16'h0055, F_NONE);

        // SUB in flight frozen by ce=0 for 4 cycles
        drive(1, 4'd1, 2'b11, 8'h20, 8'h05, 0);
        tick();
        ce = 1'b0;
        go_idle();
        for (int i = 0; i < 4; i++) tick();
        check_out("sub_frozen", 16'h0055, F_NONE);
        ce = 1'b1;
        tick();
        check_out("sub_resume", 16'h001B, F_NONE);

        // Reset during MUL1 aborts the multiply
        run_op("pre_rst",      1, 4'd0, 2'b11, 8'hFF, 8'h01, 0, 16'h0100, F_COUT);
        drive(1, 4'd9, 2'b11, 8'h03, 8'h04, 0);
        tick();
        rst = 1'b1;
        go_idle();
        tick();
        check_out("rst_mul1", 16'h0000, F_NONE);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check_out("rst_no_mul", 16'h0000, F_NONE);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
